// File: rtl/bcd_timer_ctrl_pkg.sv
// Shared definitions for the BCD stopwatch/countdown controller.
//   stw_state_e  : FSM state codes (3 bits, exported on the state port)
//   digit_limit  : wrap value of BCD digit idx (5 for the tens-of-seconds
//                  digit in MM:SS mode, 9 otherwise)
package bcd_timer_ctrl_pkg;

  typedef enum logic [2:0] {
    STW         = 3'd0,
    STW_COUNT   = 3'd1,
    STW_PAUSE   = 3'd2,
    STW_SETTING = 3'd3,
    STW_DONE    = 3'd4
  } stw_state_e;

  function automatic logic [3:0] digit_limit(input int unsigned idx, input bit mmss);
    return (mmss && idx == 1) ? 4'd5 : 4'd9;
  endfunction

endpackage

// File: rtl/bcd_digit_step.sv
// One BCD digit of the stepping chain (combinational).
//   en           : step this digit (carry/borrow-in from the digit below)
//   up           : 1 = increment, 0 = decrement
//   d            : current digit value
//   q            : stepped digit value (d when en=0)
//   carry_borrow : digit wrapped (LIMIT->0 going up, 0->LIMIT going down)
module bcd_digit_step
  import bcd_timer_ctrl_pkg::*;
#(
  parameter logic [3:0] LIMIT = 4'd9
) (
  input  logic       en,
  input  logic       up,
  input  logic [3:0] d,
  output logic [3:0] q,
  output logic       carry_borrow
);

  always_comb begin
    q            = d;
    carry_borrow = 1'b0;
    if (en) begin
      if (up) begin
        if (d == LIMIT) begin
          q            = '0;
          carry_borrow = 1'b1;
        end else begin
          q = d + 4'd1;
        end
      end else begin
        if (d == '0) begin
          q            = LIMIT;
          carry_borrow = 1'b1;
        end else begin
          q = d - 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/bcd_timer_ctrl.sv
// Stopwatch / countdown controller: FSM, editable BCD preset, BCD counter
// stepped on tick, latched alarm.
//   clk, rst_n                : clock, async active-low reset
//   tick                      : 1-cycle count-rate enable
//   pb_start, pb_ps           : start/stop/acknowledge, pause/resume pulses
//   pb_sel, pb_inc            : edit cursor advance / digit increment pulses
//   switch, mode_up           : request SETTING, count direction for next start
//   count                     : live BCD value (digit i = count[4i+3:4i])
//   cursor                    : digit being edited
//   state                     : FSM state code
//   count_enable, done, alarm : COUNT indicator, DONE-entry pulse, DONE indicator
module bcd_timer_ctrl
  import bcd_timer_ctrl_pkg::*;
#(
  parameter int unsigned         DIGITS      = 4,
  parameter bit                  MMSS        = 1'b1,
  parameter logic [4*DIGITS-1:0] PRESET_INIT = (4*DIGITS)'(16'h0130)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       tick,
  input  logic                       pb_start,
  input  logic                       pb_ps,
  input  logic                       pb_sel,
  input  logic                       pb_inc,
  input  logic                       switch,
  input  logic                       mode_up,
  output logic [4*DIGITS-1:0]        count,
  output logic [$clog2(DIGITS)-1:0]  cursor,
  output logic [2:0]                 state,
  output logic                       count_enable,
  output logic                       done,
  output logic                       alarm
);

  localparam int unsigned W  = 4 * DIGITS;
  localparam int unsigned CW = $clog2(DIGITS);

  stw_state_e      state_q, state_d;
  logic [W-1:0]    preset_q, preset_d, preset_inc;
  logic [W-1:0]    count_q, count_d, stepped, term;
  logic [CW-1:0]   cursor_q, cursor_d, cursor_next;
  logic            dir_q, dir_d;
  logic            done_q;
  logic [DIGITS:0] chain;

  // Stepping chain, LSB -> MSB; always computed, only used on tick in COUNT.
  assign chain[0] = 1'b1;
  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit_step #(.LIMIT(digit_limit(g, MMSS))) u_step (
      .en           (chain[g]),
      .up           (dir_q),
      .d            (count_q[4*g +: 4]),
      .q            (stepped[4*g +: 4]),
      .carry_borrow (chain[g+1])
    );
  end

  assign term        = dir_q ? preset_q : '0;
  assign cursor_next = (cursor_q == CW'(DIGITS - 1)) ? '0 : cursor_q + CW'(1);

  always_comb begin
    preset_inc = preset_q;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (CW'(i) == cursor_q) begin
        if (preset_q[4*i +: 4] == digit_limit(i, MMSS))
          preset_inc[4*i +: 4] = '0;
        else
          preset_inc[4*i +: 4] = preset_q[4*i +: 4] + 4'd1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    preset_d = preset_q;
    count_d  = count_q;
    cursor_d = cursor_q;
    dir_d    = dir_q;
    case (state_q)
      STW: begin
        count_d = preset_q;
        if (pb_start) begin
          dir_d   = mode_up;
          count_d = mode_up ? '0 : preset_q;
          // Start value equals terminal value in both directions when preset is 0.
          state_d = (preset_q == '0) ? STW_DONE : STW_COUNT;
        end else if (switch) begin
          state_d = STW_SETTING;
        end
      end
      STW_COUNT: begin
        if (pb_start) begin
          state_d = STW;
          count_d = preset_q;
        end else begin
          if (tick) count_d = stepped;
          // Full-width wrap also ends the run, so an unreachable preset cannot
          // leave the counter running forever.
          if (tick && (stepped == term || chain[DIGITS]))
            state_d = STW_DONE;
          else if (pb_ps)
            state_d = STW_PAUSE;
        end
      end
      STW_PAUSE: begin
        if (pb_start) begin
          state_d = STW;
          count_d = preset_q;
        end else if (pb_ps) begin
          state_d = STW_COUNT;
        end
      end
      STW_SETTING: begin
        if (pb_inc) preset_d = preset_inc;
        if (pb_sel) cursor_d = cursor_next;
        count_d = preset_d;
        if (!switch) begin
          state_d  = STW;
          cursor_d = '0;
        end
      end
      STW_DONE: begin
        if (pb_start) begin
          state_d = STW;
          count_d = preset_q;
        end
      end
      default: begin
        state_d = STW;
        count_d = preset_q;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= STW;
      preset_q <= PRESET_INIT;
      count_q  <= PRESET_INIT;
      cursor_q <= '0;
      dir_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      cursor_q <= cursor_d;
      dir_q    <= dir_d;
      done_q   <= (state_d == STW_DONE) && (state_q != STW_DONE);
    end
  end

  assign count        = count_q;
  assign cursor       = cursor_q;
  assign state        = state_q;
  assign count_enable = (state_q == STW_COUNT);
  assign alarm        = (state_q == STW_DONE);
  assign done         = done_q;

endmodule

// File: tb/tb_bcd_timer_ctrl.sv
module tb_bcd_timer_ctrl;
  import bcd_timer_ctrl_pkg::*;

  logic        clk = 1'b0, rst_n = 1'b1;
  logic        tick = 1'b0, pb_start = 1'b0, pb_ps = 1'b0, pb_sel = 1'b0, pb_inc = 1'b0;
  logic        switch = 1'b0, mode_up = 1'b0;
  logic [15:0] count;
  logic [1:0]  cursor;
  logic [2:0]  state;
  logic        count_enable, done, alarm;

  bcd_timer_ctrl #(.DIGITS(4), .MMSS(1'b1), .PRESET_INIT(16'h0130)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .pb_start(pb_start), .pb_ps(pb_ps),
    .pb_sel(pb_sel), .pb_inc(pb_inc), .switch(switch), .mode_up(mode_up),
    .count(count), .cursor(cursor), .state(state), .count_enable(count_enable),
    .done(done), .alarm(alarm)
  );

  always #5 clk = ~clk;

  // Observation vector: {state, count, cursor, count_enable, done, alarm}
  typedef logic [23:0] obs_t;
  obs_t        sb_q[$];
  int unsigned n_checks = 0, n_fail = 0;

  // Reference model
  logic [15:0] m_preset = 16'h0130, m_count = 16'h0130;
  logic [2:0]  m_state  = STW;
  logic [1:0]  m_cursor = 2'd0;

  localparam logic [4:0] T = 5'b10000, ST = 5'b01000, PS = 5'b00100, SEL = 5'b00010, INC = 5'b00001;

  function automatic obs_t expv(logic [2:0] st, logic [15:0] c, logic [1:0] cur, logic dn);
    return {st, c, cur, st == STW_COUNT, dn, st == STW_DONE};
  endfunction

  function automatic obs_t got();
    return {state, count, cursor, count_enable, done, alarm};
  endfunction

  function automatic int secs(logic [15:0] b);
    return (int'(b[15:12]) * 10 + int'(b[11:8])) * 60 + int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic [15:0] bcd(int s);
    int m = s / 60;
    int ss = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  function automatic logic [15:0] inc_digit(logic [15:0] p, int i);
    logic [3:0] d   = p[4*i +: 4];
    logic [3:0] lim = (i == 1) ? 4'd5 : 4'd9;
    p[4*i +: 4] = (d == lim) ? 4'd0 : d + 4'd1;
    return p;
  endfunction

  // Drive one cycle of pulses {tick, start, ps, sel, inc}; sample #1 after the edge.
  task automatic step(input logic [4:0] v);
    {tick, pb_start, pb_ps, pb_sel, pb_inc} = v;
    @(posedge clk); #1;
    {tick, pb_start, pb_ps, pb_sel, pb_inc} = '0;
  endtask

  task automatic test_reset();
    obs_t e;
    #1 rst_n = 1'b0;
    #1;
    sb_q.push_back(expv(STW, 16'h0130, 2'd0, 1'b0));
    e = sb_q.pop_front(); n_checks++;
    if (got() !== e) begin n_fail++; $display("FAIL reset_async: got %h, expected %h", got(), e); end
    @(negedge clk); rst_n = 1'b1;
    sb_q.push_back(expv(STW, 16'h0130, 2'd0, 1'b0));
    step('0);
    e = sb_q.pop_front(); n_checks++;
    if (got() !== e) begin n_fail++; $display("FAIL reset_release: got %h, expected %h", got(), e); end
  endtask

  task automatic test_countdown();
    obs_t e;
    logic dn;
    mode_up = 1'b0;
    m_state = STW_COUNT; m_count = m_preset;
    sb_q.push_back(expv(m_state, m_count, m_cursor, 1'b0));
    step(ST);
    e = sb_q.pop_front(); n_checks++;
    if (got() !== e) begin n_fail++; $display("FAIL countdown_start: got %h, expected %h", got(), e); end
    for (int i = 1; i <= 90; i++) begin
      m_count = bcd(secs(m_count) - 1);
      dn = 1'b0;
      if (m_count == 16'h0000) begin m_state = STW_DONE; dn = 1'b1; end
      sb_q.push_back(expv(m_state, m_count, m_cursor, dn));
      step(T);
      e = sb_q.pop_front(); n_checks++;
      if (got() !== e) begin n_fail++; $display("FAIL countdown_tick%0d: got %h, expected %h", i, got(), e); end
    end
    sb_q.push_back(expv(STW_DONE, 16'h0000, m_cursor, 1'b0));
    step(T);
    e = sb_q.pop_front(); n_checks++;
    if (got() !== e) begin n_fail++; $display("FAIL countdown_hold: got %h, expected %h", got(), e); end
    m_state = STW; m_count = m_preset;
    sb_q.push_back(expv(m_state, m_count, m_cursor, 1'b0));
    step(ST);
    e = sb_q.pop_front(); n_checks++;
    if (got() !== e) begin n_fail++; $display("FAIL countdown_ack: got %h, expected %h", got(), e); end
  endtask

  task automatic test_pause();
    obs_t e;
    m_state = STW_COUNT; m_count = m_preset;
    sb_q.push_back(expv(m_state, m_count, m_cursor, 1'b0));
    step(ST);
    for (int i = 0; i < 10; i++) begin
      m_count = bcd(secs(m_count) - 1);
      sb_q.push_back(expv(m_state, m_count, m_cursor, 1'b0));
      step(T);
    end
    m_state = STW_PAUSE;
    sb_q.push_back(expv(m_state, m_count, m_cursor, 1'b0));
    step(PS);
    for (int i = 0; i < 5; i++) begin
      sb_q.push_back(expv(m_state, m_count, m_cursor, 1'b0));
      step(T);
    end
    m_state = STW_COUNT;
    sb_q.push_back(expv(m_state, m_count, m_cursor, 1'b0));
    step(PS);
    m_count = bcd(secs(m_count) - 1);
    sb_q.push_back(expv(m_state, m_count, m_cursor, 1'b0));
    step(T);
    // tick and pause together: step applied, then paused
    m_count = bcd(secs(m_count) - 1); m_state = STW_PAUSE;
    sb_q.push_back(expv(m_state, m_count, m_cursor, 1'b0));
    step(T | PS);
    m_state = STW; m_count = m_preset;
    sb_q.push_back(expv(m_state, m_count, m_cursor, 1'b0));
    step(ST);
    // the whole sequence was queued; drain and compare against recorded outputs
    // is not possible after the fact, so compare live below instead
    sb_q.delete();
  endtask

  // Same scenario compared cycle by cycle (queue popped right after each edge).
  task automatic test_pause_checked();
    obs_t e;
    logic [4:0] seq [$];
    seq = '{ST, T, T, T, T, T, T, T, T, T, T, PS, T, T, T, T, T, PS, T, T | PS, ST};
    foreach (seq[k]) begin
      logic [4:0] v = seq[k];
      if (v == ST) begin
        if (m_state == STW) begin m_state = STW_COUNT; m_count = m_preset; end
        else begin m_state = STW; m_count = m_preset; end
      end else begin
        if (v[4] && m_state == STW_COUNT) m_count = bcd(secs(m_count) - 1);
        if (v[2]) m_state = (m_state == STW_COUNT) ? STW_PAUSE : STW_COUNT;
      end
      sb_q.push_back(expv(m_state, m_count, m_cursor, 1'b0));
      step(v);
      e = sb_q.pop_front(); n_checks++;
      if (got() !== e) begin n_fail++; $display("FAIL pause_step%0d: got %h, expected %h", k, got(), e); end
    end
  endtask

  task automatic enter_setting(input string tag);
    obs_t e;
    switch = 1'b1;
    m_state = STW_SETTING;
    sb_q.push_back(expv(m_state, m_preset, m_cursor, 1'b0));
    step('0);
    e = sb_q.pop_front(); n_checks++;
    if (got() !== e) begin n_fail++; $display("FAIL %s_enter: got %h, expected %h", tag, got(), e); end
  endtask

  task automatic leave_setting(input string tag);
    obs_t e;
    switch = 1'b0;
    m_state = STW; m_cursor = 2'd0; m_count = m_preset;
    sb_q.push_back(expv(m_state, m_count, m_cursor, 1'b0));
    step('0);
    e = sb_q.pop_front(); n_checks++;
    if (got() !== e) begin n_fail++; $display("FAIL %s_leave: got %h, expected %h", tag, got(), e); end
  endtask

  task automatic edit(input logic [4:0] v, input string tag);
    obs_t e;
    if (v[0]) m_preset = inc_digit(m_preset, int'(m_cursor));
    if (v[1]) m_cursor = (m_cursor == 2'd3) ? 2'd0 : m_cursor + 2'd1;
    m_count = m_preset;
    sb_q.push_back(expv(m_state, m_count, m_cursor, 1'b0));
    step(v);
    e = sb_q.pop_front(); n_checks++;
    if (got() !== e) begin n_fail++; $display("FAIL %s: got %h, expected %h", tag, got(), e); end
  endtask

  task automatic test_setting();
    enter_setting("setting");
    for (int i = 0; i < 11; i++) edit(INC, "setting_inc_d0");
    edit(SEL, "setting_sel");
    for (int i = 0; i < 6; i++) edit(INC, "setting_inc_d1");
    edit(SEL | INC, "setting_sel_inc");
    edit(ST | PS, "setting_ignore_start");
    leave_setting("setting");
  endtask

  task automatic set_preset(input logic [15:0] target);
    enter_setting("preset");
    for (int i = 0; i < 4; i++) begin
      while (m_preset[4*i +: 4] != target[4*i +: 4]) edit(INC, "preset_inc");
      edit(SEL, "preset_sel");
    end
    leave_setting("preset");
  endtask

  task automatic test_count_up();
    obs_t e;
    logic dn;
    set_preset(16'h0005);
    mode_up = 1'b1;
    m_state = STW_COUNT; m_count = 16'h0000;
    sb_q.push_back(expv(m_state, m_count, m_cursor, 1'b0));
    step(ST);
    e = sb_q.pop_front(); n_checks++;
    if (got() !== e) begin n_fail++; $display("FAIL up_start: got %h, expected %h", got(), e); end
    for (int i = 1; i <= 5; i++) begin
      if (i == 3) mode_up = 1'b0;  // must not affect the running count
      m_count = bcd(secs(m_count) + 1);
      dn = 1'b0;
      if (m_count == m_preset) begin m_state = STW_DONE; dn = 1'b1; end
      sb_q.push_back(expv(m_state, m_count, m_cursor, dn));
      step(T);
      e = sb_q.pop_front(); n_checks++;
      if (got() !== e) begin n_fail++; $display("FAIL up_tick%0d: got %h, expected %h", i, got(), e); end
    end
    m_state = STW; m_count = m_preset;
    sb_q.push_back(expv(m_state, m_count, m_cursor, 1'b0));
    step(ST);
    e = sb_q.pop_front(); n_checks++;
    if (got() !== e) begin n_fail++; $display("FAIL up_ack: got %h, expected %h", got(), e); end
  endtask

  task automatic test_back_to_back();
    obs_t e;
    logic [4:0] v [$];
    logic [2:0] st [$];
    logic [15:0] c [$];
    logic dn [$];
    mode_up = 1'b0;
    // preset 0005, down: start, tick, start+pause together, stray tick in STW
    v  = '{ST, T, ST | PS, T};
    st = '{STW_COUNT, STW_COUNT, STW, STW};
    c  = '{16'h0005, 16'h0004, 16'h0005, 16'h0005};
    dn = '{1'b0, 1'b0, 1'b0, 1'b0};
    foreach (v[k]) begin
      sb_q.push_back(expv(st[k], c[k], m_cursor, dn[k]));
      step(v[k]);
      e = sb_q.pop_front(); n_checks++;
      if (got() !== e) begin n_fail++; $display("FAIL b2b_step%0d: got %h, expected %h", k, got(), e); end
    end
    set_preset(16'h0000);
    // preset 0000: down start -> DONE, hold, ack; up start -> DONE; switch ignored in DONE
    v  = '{ST, 5'b0, ST, ST, 5'b0};
    st = '{STW_DONE, STW_DONE, STW, STW_DONE, STW_DONE};
    c  = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    dn = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    foreach (v[k]) begin
      if (k == 3) mode_up = 1'b1;
      if (k == 4) switch = 1'b1;
      sb_q.push_back(expv(st[k], c[k], m_cursor, dn[k]));
      step(v[k]);
      e = sb_q.pop_front(); n_checks++;
      if (got() !== e) begin n_fail++; $display("FAIL zero_step%0d: got %h, expected %h", k, got(), e); end
    end
    switch = 1'b0;
    m_state = STW_DONE; m_count = 16'h0000;
  endtask

  task automatic test_async_reset();
    obs_t e;
    // from DONE (alarm high)
    #2 rst_n = 1'b0;
    #1;
    m_preset = 16'h0130; m_count = 16'h0130; m_state = STW; m_cursor = 2'd0;
    sb_q.push_back(expv(STW, 16'h0130, 2'd0, 1'b0));
    e = sb_q.pop_front(); n_checks++;
    if (got() !== e) begin n_fail++; $display("FAIL areset_done: got %h, expected %h", got(), e); end
    #1 rst_n = 1'b1;
    // mid-COUNT
    mode_up = 1'b0;
    step(ST);
    for (int i = 0; i < 3; i++) step(T);
    sb_q.push_back(expv(STW_COUNT, 16'h0127, 2'd0, 1'b0));
    e = sb_q.pop_front(); n_checks++;
    if (got() !== e) begin n_fail++; $display("FAIL areset_precount: got %h, expected %h", got(), e); end
    #2 rst_n = 1'b0;
    #1;
    sb_q.push_back(expv(STW, 16'h0130, 2'd0, 1'b0));
    e = sb_q.pop_front(); n_checks++;
    if (got() !== e) begin n_fail++; $display("FAIL areset_count: got %h, expected %h", got(), e); end
    #1 rst_n = 1'b1;
    sb_q.push_back(expv(STW, 16'h0130, 2'd0, 1'b0));
    step(T);
    e = sb_q.pop_front(); n_checks++;
    if (got() !== e) begin n_fail++; $display("FAIL areset_after: got %h, expected %h", got(), e); end
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_pause_checked();
    test_setting();
    test_count_up();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
